rgb_stream_source: RTL and testbench

- Video stream transmitter for the edge-detection pipeline. Generates vsync/hsync/de timing, fetches packed RGB pixels from a frame memory read port, and drives the per-channel RGB stream consumed by the grayscale stage.
- Produces the same vsync/hsync/de/data interface that downstream filters receive, with syncs active-high and data zero outside de.

---
 rtl/video_stream_pkg.sv | 35 +++
 rtl/video_timing_counter.sv | 81 ++++++++
 rtl/rgb_stream_source.sv | 219 +++++++++++++++++++++
 tb/tb_rgb_stream_source.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/video_stream_pkg.sv
// video_stream_pkg
// Shared types and helpers for the video stream source.
//   state_t     : transmitter FSM states (IDLE, RUN, DRAIN)
//   rgb_pixel_t : packed {r, g, b} pixel at PIX_W bits per channel
//   timing_t    : per-slot timing flags carried down the alignment pipe
//   calc_total  : line/frame total from active size and porch widths
package video_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int PIX_W = 8;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb_pixel_t;

  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
    logic last;
  } timing_t;

  function automatic int calc_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// video_timing_counter
// Horizontal/vertical slot counters with raster timing decode.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   clr       : synchronous return of both counters to slot (0,0)
//   en        : advance one slot per clock; decode outputs are 0 when low
//   bar       : colour-bar index of the current slot (only with
//               RGB_SRC_TEST_PATTERN_EN defined)
//   de, hsync, vsync : active-video and sync flags of the current slot
//   last      : current slot is the final slot of the frame
module video_timing_counter
  import video_stream_pkg::*;
#(
  parameter int H_ACTIVE = 320,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 16,
  parameter int H_BP     = 8,
  parameter int V_ACTIVE = 240,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic       en,
`ifdef RGB_SRC_TEST_PATTERN_EN
  output logic [2:0] bar,
`endif
  output logic       de,
  output logic       hsync,
  output logic       vsync,
  output logic       last
);

  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] h_cnt_reg;
  logic [VW-1:0] v_cnt_reg;
  int            h_i;
  int            v_i;
  logic          h_last;
  logic          v_last;

  assign h_i    = int'(h_cnt_reg);
  assign v_i    = int'(v_cnt_reg);
  assign h_last = (h_i == H_TOTAL - 1);
  assign v_last = (v_i == V_TOTAL - 1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (clr) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (en) begin
      if (h_last) begin
        h_cnt_reg <= '0;
        v_cnt_reg <= v_last ? '0 : v_cnt_reg + VW'(1);
      end else begin
        h_cnt_reg <= h_cnt_reg + HW'(1);
      end
    end
  end

  // Flags are qualified by en so idle/drain cycles never look like slots.
  assign de    = en && (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
  assign hsync = en && (h_i >= H_ACTIVE + H_FP) && (h_i < H_ACTIVE + H_FP + H_SYNC);
  assign vsync = en && (v_i >= V_ACTIVE + V_FP) && (v_i < V_ACTIVE + V_FP + V_SYNC);
  assign last  = en && h_last && v_last;

`ifdef RGB_SRC_TEST_PATTERN_EN
  // Eight equal-width bars across the active line; only meaningful while de.
  assign bar = 3'((h_i * 8) / H_ACTIVE);
`endif

endmodule

// File: rtl/rgb_stream_source.sv
// rgb_stream_source
// Raster video transmitter: generates vsync/hsync/de, reads packed RGB
// pixels from a frame memory and drives per-channel pixel outputs.
// Optional build macro RGB_SRC_TEST_PATTERN_EN adds i_pattern, which
// replaces memory pixels by eight vertical colour bars for a whole frame.
// Ports:
//   clk, rstn       : clock, asynchronous active-low reset
//   i_start         : start request, honoured only when idle
//   i_continuous    : sampled at the last slot; 1 runs another frame
//   o_busy          : frame in progress or pipeline draining
//   o_frame_done    : pulse as the last slot of a frame leaves the outputs
//   o_rd_en/o_rd_addr/i_rd_data : frame memory read port ({R,G,B},
//                     data valid MEM_LAT clocks after o_rd_en)
//   o_vsync, o_hsync, o_de, o_r/g/b_data : output video stream
module rgb_stream_source
  import video_stream_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int H_ACTIVE = 320,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 16,
  parameter int H_BP     = 8,
  parameter int V_ACTIVE = 240,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 2,
  parameter int ADDR_W   = 17,
  parameter int MEM_LAT  = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_start,
  input  logic               i_continuous,
`ifdef RGB_SRC_TEST_PATTERN_EN
  input  logic               i_pattern,
`endif
  output logic               o_busy,
  output logic               o_frame_done,
  output logic               o_rd_en,
  output logic [ADDR_W-1:0]  o_rd_addr,
  input  logic [3*WIDTH-1:0] i_rd_data,
  output logic               o_vsync,
  output logic               o_hsync,
  output logic               o_de,
  output logic [WIDTH-1:0]   o_r_data,
  output logic [WIDTH-1:0]   o_g_data,
  output logic [WIDTH-1:0]   o_b_data
);

  localparam int DW = (MEM_LAT + 1 > 1) ? $clog2(MEM_LAT + 1) : 1;

  state_t            state_reg;
  state_t            state_next;
  logic [DW-1:0]     drain_cnt_reg;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic              run;
  logic              de_c;
  logic              hsync_c;
  logic              vsync_c;
  logic              last_c;
  timing_t           tm_c;
  timing_t           tm_sr_reg [MEM_LAT];
  timing_t           tm_d;

  assign run  = (state_reg == RUN);
  assign tm_c = {de_c, hsync_c, vsync_c, last_c};
  assign tm_d = tm_sr_reg[MEM_LAT-1];

`ifdef RGB_SRC_TEST_PATTERN_EN
  logic [2:0] bar_c;
  logic [2:0] bar_sr_reg [MEM_LAT];
  logic [2:0] bar_d;
  logic       pattern_reg;

  assign bar_d = bar_sr_reg[MEM_LAT-1];

  // Captured at every frame start (fresh start or seamless continuation).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pattern_reg <= 1'b0;
    end else if ((state_reg == IDLE && i_start) || (run && last_c && i_continuous)) begin
      pattern_reg <= i_pattern;
    end
  end
`endif

  video_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (state_reg == IDLE),
    .en    (run),
`ifdef RGB_SRC_TEST_PATTERN_EN
    .bar   (bar_c),
`endif
    .de    (de_c),
    .hsync (hsync_c),
    .vsync (vsync_c),
    .last  (last_c)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    o_busy     = 1'b0;
    o_rd_en    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_start) state_next = RUN;
      end
      RUN: begin
        o_busy = 1'b1;
`ifdef RGB_SRC_TEST_PATTERN_EN
        o_rd_en = de_c && !pattern_reg;
`else
        o_rd_en = de_c;
`endif
        if (last_c && !i_continuous) state_next = DRAIN;
      end
      DRAIN: begin
        o_busy = 1'b1;
        if (int'(drain_cnt_reg) == MEM_LAT) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // DRAIN lasts MEM_LAT+1 clocks: enough for the final slot to reach the outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drain_cnt_reg <= '0;
    end else if (state_reg == DRAIN) begin
      drain_cnt_reg <= drain_cnt_reg + DW'(1);
    end else begin
      drain_cnt_reg <= '0;
    end
  end

  // Address clears at the last slot so a continued frame starts at 0
  // and the port reads 0 once the source goes idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_addr_reg <= '0;
    end else if (state_reg == IDLE || (run && last_c)) begin
      rd_addr_reg <= '0;
    end else if (run && de_c) begin
      rd_addr_reg <= rd_addr_reg + ADDR_W'(1);
    end
  end

  assign o_rd_addr = rd_addr_reg;

  // Timing flags wait MEM_LAT clocks so they line up with the read data.
  for (genvar gi = 0; gi < MEM_LAT; gi++) begin : g_align
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        tm_sr_reg[gi] <= '0;
`ifdef RGB_SRC_TEST_PATTERN_EN
        bar_sr_reg[gi] <= '0;
`endif
      end else begin
        tm_sr_reg[gi] <= (gi == 0) ? tm_c : tm_sr_reg[(gi == 0) ? 0 : gi-1];
`ifdef RGB_SRC_TEST_PATTERN_EN
        bar_sr_reg[gi] <= (gi == 0) ? bar_c : bar_sr_reg[(gi == 0) ? 0 : gi-1];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_de         <= 1'b0;
      o_hsync      <= 1'b0;
      o_vsync      <= 1'b0;
      o_frame_done <= 1'b0;
      o_r_data     <= '0;
      o_g_data     <= '0;
      o_b_data     <= '0;
    end else begin
      o_de         <= tm_d.de;
      o_hsync      <= tm_d.hsync;
      o_vsync      <= tm_d.vsync;
      o_frame_done <= tm_d.last;
      if (!tm_d.de) begin
        o_r_data <= '0;
        o_g_data <= '0;
        o_b_data <= '0;
      end
`ifdef RGB_SRC_TEST_PATTERN_EN
      else if (pattern_reg) begin
        o_r_data <= {WIDTH{bar_d[2]}};
        o_g_data <= {WIDTH{bar_d[1]}};
        o_b_data <= {WIDTH{bar_d[0]}};
      end
`endif
      else begin
        o_r_data <= i_rd_data[3*WIDTH-1 -: WIDTH];
        o_g_data <= i_rd_data[2*WIDTH-1 -: WIDTH];
        o_b_data <= i_rd_data[WIDTH-1 -: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_rgb_stream_source.sv
// tb_rgb_stream_source
// Directed bench for rgb_stream_source on a tiny 8x6-slot raster
// (4x3 active). Memory model returns {a,a,a} for address a, one clock
// after the read strobe. With RGB_SRC_TEST_PATTERN_EN defined the
// colour-bar mode is exercised as well.
module tb_rgb_stream_source;
  import video_stream_pkg::*;

  localparam int W      = 8;
  localparam int AW     = 8;
  localparam int SLOTS  = 48;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          i_start = 1'b0;
  logic          i_continuous = 1'b0;
`ifdef RGB_SRC_TEST_PATTERN_EN
  logic          i_pattern = 1'b0;
`endif
  logic          o_busy;
  logic          o_frame_done;
  logic          o_rd_en;
  logic [AW-1:0] o_rd_addr;
  rgb_pixel_t    mem_q = '0;
  logic          o_vsync;
  logic          o_hsync;
  logic          o_de;
  logic [W-1:0]  o_r_data;
  logic [W-1:0]  o_g_data;
  logic [W-1:0]  o_b_data;
  logic [31:0]   stream_obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rgb_stream_source #(
    .WIDTH(W), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .ADDR_W(AW), .MEM_LAT(1)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_start      (i_start),
    .i_continuous (i_continuous),
`ifdef RGB_SRC_TEST_PATTERN_EN
    .i_pattern    (i_pattern),
`endif
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_rd_en      (o_rd_en),
    .o_rd_addr    (o_rd_addr),
    .i_rd_data    (mem_q),
    .o_vsync      (o_vsync),
    .o_hsync      (o_hsync),
    .o_de         (o_de),
    .o_r_data     (o_r_data),
    .o_g_data     (o_g_data),
    .o_b_data     (o_b_data)
  );

  // Frame memory: pixel at address a is {a,a,a}, one clock latency.
  always @(posedge clk) begin
    if (o_rd_en) begin
      mem_q.r <= o_rd_addr;
      mem_q.g <= o_rd_addr;
      mem_q.b <= o_rd_addr;
    end
  end

  assign stream_obs = {4'h0, o_vsync, o_hsync, o_de, o_frame_done, o_r_data, o_g_data, o_b_data};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected output for slot k (0..47) of a frame: h = k%8, v = k/8.
  function automatic logic [31:0] exp_out(input int k, input bit bars);
    int h, v;
    logic de, hs, vs, fd;
    logic [7:0] d;
    logic [23:0] bar_rgb [4];
    bar_rgb[0] = 24'h000000;
    bar_rgb[1] = 24'h00FF00;
    bar_rgb[2] = 24'hFF0000;
    bar_rgb[3] = 24'hFFFF00;
    h  = k % 8;
    v  = k / 8;
    de = (h < 4) && (v < 3);
    hs = (h == 5) || (h == 6);
    vs = (v == 4);
    fd = (k == SLOTS - 1);
    d  = de ? 8'(v * 4 + h) : 8'h00;
    if (bars) return {4'h0, vs, hs, de, fd, de ? bar_rgb[h] : 24'h0};
    return {4'h0, vs, hs, de, fd, d, d, d};
  endfunction

  // Start from IDLE and run n back-to-back frames, checking every cycle.
  // Cycle c=0 is the first counter slot; output slot k appears at c=k+2.
  task automatic run_frames(input int n, input bit poke, input bit bars);
    int total, de_cnt, rd_cnt, done_cnt, first_done, second_done, s, h, v, k;
    logic exp_en;
    total = SLOTS * n;
    de_cnt = 0; rd_cnt = 0; done_cnt = 0; first_done = -1; second_done = -1;
    i_continuous = (n > 1);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 0; c < total + 4; c++) begin
      if (c == SLOTS * (n - 1)) i_continuous = 1'b0;
      i_start = poke && (c == 10 || c == 30);
      s = c % SLOTS;
      h = s % 8;
      v = s / 8;
      exp_en = (c < total) && (h < 4) && (v < 3) && !bars;
      chk("rd_en", 32'(o_rd_en), 32'(exp_en));
      if (exp_en) chk("rd_addr", 32'(o_rd_addr), 32'(v * 4 + h));
      k = c - 2;
      chk("stream", stream_obs, (k >= 0 && k < total) ? exp_out(k % SLOTS, bars) : 32'h0);
      chk("busy", 32'(o_busy), 32'(c < total + 2));
      if (o_de) de_cnt++;
      if (o_rd_en) rd_cnt++;
      if (o_frame_done) begin
        done_cnt++;
        if (first_done < 0) first_done = c;
        else if (second_done < 0) second_done = c;
      end
      tick();
    end
    i_start = 1'b0;
    chk("de_total", 32'(de_cnt), 32'(12 * n));
    chk("rd_total", 32'(rd_cnt), bars ? 32'h0 : 32'(12 * n));
    chk("done_count", 32'(done_cnt), 32'(n));
    // Last output slot of a frame is 47 clocks after its first (c=2).
    chk("done_pos", 32'(first_done), 32'd49);
    if (n > 1) chk("done_gap", 32'(second_done - first_done), 32'd48);
    $display("frames=%0d poke=%0d bars=%0d reads=%0d de_beats=%0d frame_done=%0d",
             n, poke, bars, rd_cnt, de_cnt, done_cnt);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_stream", stream_obs, 32'h0);
    chk("reset_busy", 32'(o_busy), 32'h0);
    chk("reset_rd", {23'h0, o_rd_en, o_rd_addr}, 32'h0);
    rstn = 1'b1;
    tick();
    tick();
    chk("idle_busy", 32'(o_busy), 32'h0);
    $display("reset: busy=%0d rd_en=%0d", o_busy, o_rd_en);

    // Single frame, memory data path
    run_frames(1, 1'b0, 1'b0);
    // Two continuous frames
    run_frames(2, 1'b0, 1'b0);
    // Start pulses while running are ignored
    run_frames(1, 1'b1, 1'b0);

    // Asynchronous reset at line 1, h=2
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("abort_done", 32'(o_frame_done), 32'h0);
      tick();
    end
    chk("pre_abort_de", 32'(o_de), 32'h1);
    chk("pre_abort_rd", {23'h0, o_rd_en, o_rd_addr}, {23'h0, 1'b1, 8'd6});
    rstn = 1'b0;
    #1;
    chk("abort_stream", stream_obs, 32'h0);
    chk("abort_busy", 32'(o_busy), 32'h0);
    chk("abort_rd", {23'h0, o_rd_en, o_rd_addr}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("abort_hold", {27'h0, o_busy, o_frame_done, o_de, o_hsync, o_vsync}, 32'h0);
    end
    #3;
    rstn = 1'b1;
    tick();
    $display("abort: busy=%0d de=%0d frame_done=%0d", o_busy, o_de, o_frame_done);
    run_frames(1, 1'b0, 1'b0);

`ifdef RGB_SRC_TEST_PATTERN_EN
    i_pattern = 1'b1;
    run_frames(1, 1'b0, 1'b1);
    i_pattern = 1'b0;
    run_frames(1, 1'b0, 1'b0);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
